// File: rtl/mem_lsu.sv
// Load/store unit between the memory stage and a word-wide, 1-cycle-latency data RAM.
// Adds sub-word loads with extension, read-modify-write sub-word stores and alignment checks.
module mem_lsu #(
   parameter logic [31:0] RESET_RDATA = 32'h0
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [1:0]  req_size_i,
   input  logic        req_unsigned_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        rsp_valid_o,
   output logic        rsp_err_o,
   output logic [31:0] rsp_rdata_o,
   output logic        mem_r_en_o,
   output logic [31:0] mem_addr_r_o,
   input  logic [31:0] mem_data_r_i,
   output logic        mem_wr_en_o,
   output logic [31:0] mem_addr_w_o,
   output logic [31:0] mem_data_w_o
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_MERGE = 3'd2,
      S_WRITE = 3'd3,
      S_RESP  = 3'd4
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic        r_we;
   logic [1:0]  r_size;
   logic        r_unsigned;
   logic [31:0] r_addr;
   logic [15:0] r_wdata;
   logic        r_err;
   logic [31:0] r_rdata;
   logic [31:0] r_wword;
   logic        w_accept;
   logic        w_err;

   function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] lane,
                                                input logic [1:0] size, input logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] res;
      b = 8'(word >> {lane, 3'b000});
      h = lane[1] ? word[31:16] : word[15:0];
      case (size)
         2'b00:   res = uns ? {24'h0, b} : {{24{b[7]}}, b};
         2'b01:   res = uns ? {16'h0, h} : {{16{h[15]}}, h};
         default: res = word;
      endcase
      return res;
   endfunction

   function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [1:0] lane,
                                               input logic [1:0] size, input logic [15:0] wd);
      logic [31:0] res;
      res = word;
      case (size)
         2'b00:   res[{lane, 3'b000} +: 8] = wd[7:0];
         2'b01: begin
            if (lane[1]) res[31:16] = wd;
            else         res[15:0]  = wd;
         end
         default: res = word;
      endcase
      return res;
   endfunction

   assign w_accept = req_valid_i & req_ready_o;
   assign w_err    = (req_size_i == 2'b11) ||
                     ((req_size_i == 2'b01) && req_addr_i[0]) ||
                     ((req_size_i == 2'b10) && (req_addr_i[1:0] != 2'b00));

   // state register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // next-state logic; only word stores skip the read phase
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (!w_accept)                                 w_next = S_IDLE;
            else if (w_err)                                w_next = S_RESP;
            else if (req_we_i && (req_size_i == 2'b10))    w_next = S_WRITE;
            else                                           w_next = S_READ;
         end
         S_READ:  w_next = S_MERGE;
         S_MERGE: w_next = r_we ? S_WRITE : S_RESP;
         S_WRITE: w_next = S_IDLE;
         S_RESP:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // outputs decoded from the registered state
   always_comb begin
      req_ready_o = (r_state == S_IDLE) && !rst_i;
      mem_r_en_o  = (r_state == S_READ);
      mem_wr_en_o = (r_state == S_WRITE);
      rsp_valid_o = (r_state == S_RESP) || (r_state == S_WRITE);
      rsp_err_o   = rsp_valid_o && r_err;
   end

   // request latch, load result and write word
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_we       <= 1'b0;
         r_size     <= 2'b00;
         r_unsigned <= 1'b0;
         r_addr     <= 32'h0;
         r_wdata    <= 16'h0;
         r_err      <= 1'b0;
         r_rdata    <= RESET_RDATA;
         r_wword    <= RESET_RDATA;
      end else if (w_accept) begin
         r_we       <= req_we_i;
         r_size     <= req_size_i;
         r_unsigned <= req_unsigned_i;
         r_addr     <= req_addr_i;
         r_wdata    <= req_wdata_i[15:0];
         r_err      <= w_err;
         if (req_we_i && (req_size_i == 2'b10) && !w_err) r_wword <= req_wdata_i;
      end else if (r_state == S_MERGE) begin
         if (r_we) r_wword <= store_merge(mem_data_r_i, r_addr[1:0], r_size, r_wdata);
         else      r_rdata <= load_extract(mem_data_r_i, r_addr[1:0], r_size, r_unsigned);
      end
   end

   assign rsp_rdata_o  = r_rdata;
   assign mem_data_w_o = r_wword;
   assign mem_addr_r_o = {r_addr[31:2], 2'b00};
   assign mem_addr_w_o = {r_addr[31:2], 2'b00};

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: vector table with a response scoreboard plus
// hand-written sequences for reset mid-operation and busy-time input changes.
module tb_mem_lsu;
   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        req_valid_i, req_ready_o, req_we_i, req_unsigned_i;
   logic [1:0]  req_size_i;
   logic [31:0] req_addr_i, req_wdata_i;
   logic        rsp_valid_o, rsp_err_o;
   logic [31:0] rsp_rdata_o;
   logic        mem_r_en_o, mem_wr_en_o;
   logic [31:0] mem_addr_r_o, mem_addr_w_o, mem_data_w_o;
   logic [31:0] mem_data_r_i;

   always #5 clk_i = ~clk_i;

   mem_lsu #(.RESET_RDATA(32'h0)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
      .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
      .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
      .rsp_valid_o(rsp_valid_o), .rsp_err_o(rsp_err_o), .rsp_rdata_o(rsp_rdata_o),
      .mem_r_en_o(mem_r_en_o), .mem_addr_r_o(mem_addr_r_o), .mem_data_r_i(mem_data_r_i),
      .mem_wr_en_o(mem_wr_en_o), .mem_addr_w_o(mem_addr_w_o), .mem_data_w_o(mem_data_w_o)
   );

   // RAM model: 64 words, registered read, bench preload port
   logic [31:0] ram [0:63];
   logic        pre_en = 1'b0;
   logic [5:0]  pre_idx;
   logic [31:0] pre_val;
   always @(posedge clk_i) begin
      if (pre_en)           ram[pre_idx] <= pre_val;
      else if (mem_wr_en_o) ram[mem_addr_w_o[7:2]] <= mem_data_w_o;
      if (mem_r_en_o)       mem_data_r_i <= ram[mem_addr_r_o[7:2]];
   end

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        pre;
      logic [31:0] pre_val;
      logic        err;
      logic [31:0] rdata;
      int          lat;
      int          reads;
      int          writes;
      logic [31:0] wword;
   } vec_t;

   typedef struct {
      logic err;
      int   lat;
   } rsp_t;

   rsp_t sbq[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   vec_t vecs[21];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: event did not occur within cycle budget", name);
   endtask

   task automatic preload(input logic [5:0] idx, input logic [31:0] val);
      @(negedge clk_i);
      pre_en = 1'b1; pre_idx = idx; pre_val = val;
      @(negedge clk_i);
      pre_en = 1'b0;
   endtask

   task automatic run_op(input vec_t v);
      int nrsp, nrd, nwr, wr_cyc, bad_err;
      logic [31:0] wd, wa, ra;
      rsp_t e;
      nrsp = 0; nrd = 0; nwr = 0; wr_cyc = 0; bad_err = 0; wd = 32'h0; wa = 32'h0; ra = 32'h0;
      if (v.pre) preload(v.addr[7:2], v.pre_val);
      @(negedge clk_i);
      check("ready_before", {31'h0, req_ready_o}, 32'h1);
      req_valid_i = 1'b1; req_we_i = v.we; req_size_i = v.size; req_unsigned_i = v.uns;
      req_addr_i = v.addr; req_wdata_i = v.wdata;
      e.err = v.err; e.lat = v.lat;
      sbq.push_back(e);
      @(posedge clk_i);
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk_i);
         req_valid_i = 1'b0;
         if (mem_r_en_o) begin nrd++; ra = mem_addr_r_o; end
         if (mem_wr_en_o) begin nwr++; wd = mem_data_w_o; wa = mem_addr_w_o; wr_cyc = c; end
         if (!rsp_valid_o && rsp_err_o) bad_err++;
         if (rsp_valid_o) begin
            nrsp++;
            if (sbq.size() > 0) begin
               e = sbq.pop_front();
               check("rsp_latency", c, e.lat);
               check("rsp_err", {31'h0, rsp_err_o}, {31'h0, e.err});
            end else begin
               fail_now("unexpected_rsp");
            end
         end
      end
      if (sbq.size() > 0) begin
         fail_now("rsp_timeout");
         sbq.delete();
      end
      check("rsp_count", nrsp, 1);
      check("err_without_valid", bad_err, 0);
      check("read_count", nrd, v.reads);
      check("write_count", nwr, v.writes);
      if (v.reads > 0) check("read_addr", ra, {v.addr[31:2], 2'b00});
      if (v.writes > 0) begin
         check("write_data", wd, v.wword);
         check("write_addr", wa, {v.addr[31:2], 2'b00});
         check("write_cycle", wr_cyc, v.lat);
      end
      check("rsp_rdata", rsp_rdata_o, v.rdata);
   endtask

   initial begin
      int nwr, nrsp, wr_cyc;
      logic [31:0] wd, wa;
      rsp_t e;

      //            we    size   uns   addr   wdata        pre   pre_val      err   rdata        lat r  w  wword
      vecs[0]  = '{1'b0, 2'd0, 1'b0, 32'h43, 32'h0,        1'b1, 32'h8899AABB, 1'b0, 32'hFFFFFF88, 3, 1, 0, 32'h0};
      vecs[1]  = '{1'b0, 2'd0, 1'b1, 32'h43, 32'h0,        1'b0, 32'h0,        1'b0, 32'h00000088, 3, 1, 0, 32'h0};
      vecs[2]  = '{1'b0, 2'd1, 1'b0, 32'h40, 32'h0,        1'b0, 32'h0,        1'b0, 32'hFFFFAABB, 3, 1, 0, 32'h0};
      vecs[3]  = '{1'b0, 2'd1, 1'b1, 32'h42, 32'h0,        1'b0, 32'h0,        1'b0, 32'h00008899, 3, 1, 0, 32'h0};
      vecs[4]  = '{1'b1, 2'd0, 1'b0, 32'h41, 32'h123456CC, 1'b0, 32'h0,        1'b0, 32'h00008899, 3, 1, 1, 32'h8899CCBB};
      vecs[5]  = '{1'b0, 2'd2, 1'b0, 32'h40, 32'h0,        1'b0, 32'h0,        1'b0, 32'h8899CCBB, 3, 1, 0, 32'h0};
      vecs[6]  = '{1'b1, 2'd1, 1'b0, 32'h42, 32'h0000BEEF, 1'b1, 32'h11223344, 1'b0, 32'h8899CCBB, 3, 1, 1, 32'hBEEF3344};
      vecs[7]  = '{1'b1, 2'd2, 1'b0, 32'h44, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 32'h8899CCBB, 1, 0, 1, 32'hDEADBEEF};
      vecs[8]  = '{1'b0, 2'd2, 1'b0, 32'h44, 32'h0,        1'b0, 32'h0,        1'b0, 32'hDEADBEEF, 3, 1, 0, 32'h0};
      vecs[9]  = '{1'b0, 2'd2, 1'b0, 32'h46, 32'h0,        1'b0, 32'h0,        1'b1, 32'hDEADBEEF, 1, 0, 0, 32'h0};
      vecs[10] = '{1'b1, 2'd1, 1'b0, 32'h41, 32'h0000FFFF, 1'b0, 32'h0,        1'b1, 32'hDEADBEEF, 1, 0, 0, 32'h0};
      vecs[11] = '{1'b0, 2'd3, 1'b0, 32'h40, 32'h0,        1'b0, 32'h0,        1'b1, 32'hDEADBEEF, 1, 0, 0, 32'h0};
      vecs[12] = '{1'b1, 2'd3, 1'b0, 32'h44, 32'h5555AAAA, 1'b0, 32'h0,        1'b1, 32'hDEADBEEF, 1, 0, 0, 32'h0};
      vecs[13] = '{1'b0, 2'd0, 1'b1, 32'h44, 32'h0,        1'b0, 32'h0,        1'b0, 32'h000000EF, 3, 1, 0, 32'h0};
      vecs[14] = '{1'b0, 2'd1, 1'b0, 32'h46, 32'h0,        1'b0, 32'h0,        1'b0, 32'hFFFFDEAD, 3, 1, 0, 32'h0};
      vecs[15] = '{1'b1, 2'd0, 1'b1, 32'h47, 32'h000000AA, 1'b0, 32'h0,        1'b0, 32'hFFFFDEAD, 3, 1, 1, 32'hAAADBEEF};
      vecs[16] = '{1'b0, 2'd0, 1'b0, 32'h47, 32'h0,        1'b0, 32'h0,        1'b0, 32'hFFFFFFAA, 3, 1, 0, 32'h0};
      vecs[17] = '{1'b0, 2'd1, 1'b1, 32'h40, 32'h0,        1'b0, 32'h0,        1'b0, 32'h00003344, 3, 1, 0, 32'h0};
      vecs[18] = '{1'b0, 2'd0, 1'b0, 32'h41, 32'h0,        1'b0, 32'h0,        1'b0, 32'h00000033, 3, 1, 0, 32'h0};
      vecs[19] = '{1'b1, 2'd1, 1'b1, 32'h40, 32'hFFFF8001, 1'b0, 32'h0,        1'b0, 32'h00000033, 3, 1, 1, 32'hBEEF8001};
      vecs[20] = '{1'b1, 2'd2, 1'b0, 32'h42, 32'h12345678, 1'b0, 32'h0,        1'b1, 32'h00000033, 1, 0, 0, 32'h0};

      rst_i = 1'b1; req_valid_i = 1'b0; req_we_i = 1'b0; req_size_i = 2'd0;
      req_unsigned_i = 1'b0; req_addr_i = 32'h0; req_wdata_i = 32'h0;
      repeat (2) @(negedge clk_i);
      check("reset_ready", {31'h0, req_ready_o}, 32'h0);
      check("reset_rsp_valid", {31'h0, rsp_valid_o}, 32'h0);
      check("reset_r_en", {31'h0, mem_r_en_o}, 32'h0);
      check("reset_wr_en", {31'h0, mem_wr_en_o}, 32'h0);
      check("reset_rdata", rsp_rdata_o, 32'h0);
      check("reset_wdata", mem_data_w_o, 32'h0);
      rst_i = 1'b0;
      #1;
      check("ready_after_reset", {31'h0, req_ready_o}, 32'h1);

      for (int i = 0; i < 21; i++) run_op(vecs[i]);

      // reset asserted during MERGE of sb 0x50: no write, no response
      preload(6'h14, 32'hCAFEF00D);
      @(negedge clk_i);
      req_valid_i = 1'b1; req_we_i = 1'b1; req_size_i = 2'd0; req_unsigned_i = 1'b0;
      req_addr_i = 32'h50; req_wdata_i = 32'h00000055;
      @(posedge clk_i);
      @(negedge clk_i);
      req_valid_i = 1'b0;
      @(negedge clk_i);
      rst_i = 1'b1;
      #1;
      check("rst_mid_ready", {31'h0, req_ready_o}, 32'h0);
      nwr = 0; nrsp = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk_i);
         if (c == 1) rst_i = 1'b0;
         if (mem_wr_en_o) nwr++;
         if (rsp_valid_o) nrsp++;
      end
      check("rst_mid_writes", nwr, 0);
      check("rst_mid_rsps", nrsp, 0);
      check("rst_mid_ready_after", {31'h0, req_ready_o}, 32'h1);
      check("rst_mid_rdata", rsp_rdata_o, 32'h0);
      check("rst_mid_ram", ram[6'h14], 32'hCAFEF00D);
      run_op('{1'b0, 2'd2, 1'b0, 32'h50, 32'h0, 1'b0, 32'h0, 1'b0, 32'hCAFEF00D, 3, 1, 0, 32'h0});

      // valid held high with changing fields while busy with sb 0x48
      preload(6'h12, 32'h0);
      preload(6'h13, 32'h0);
      @(negedge clk_i);
      req_valid_i = 1'b1; req_we_i = 1'b1; req_size_i = 2'd0; req_addr_i = 32'h48;
      req_wdata_i = 32'h00000077;
      e.err = 1'b0; e.lat = 3;
      sbq.push_back(e);
      @(posedge clk_i);
      nwr = 0; nrsp = 0; wr_cyc = 0; wd = 32'h0; wa = 32'h0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk_i);
         if (mem_wr_en_o) begin nwr++; wd = mem_data_w_o; wa = mem_addr_w_o; wr_cyc = c; end
         if (rsp_valid_o) begin
            nrsp++;
            if (sbq.size() > 0) begin
               e = sbq.pop_front();
               check("busy_rsp_latency", c, e.lat);
            end else begin
               fail_now("busy_unexpected_rsp");
            end
         end
         if (c <= 2) begin
            req_size_i = 2'd2; req_addr_i = 32'h4C + 32'(c * 4);
            req_wdata_i = 32'h22220000 + 32'(c);
         end
         if (c == 3) req_valid_i = 1'b0;
      end
      if (sbq.size() > 0) begin
         fail_now("busy_rsp_timeout");
         sbq.delete();
      end
      check("busy_writes", nwr, 1);
      check("busy_rsps", nrsp, 1);
      check("busy_write_cycle", wr_cyc, 3);
      check("busy_write_addr", wa, 32'h48);
      check("busy_write_data", wd, 32'h00000077);
      check("busy_other_word", ram[6'h13], 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
Load/store unit between the core's memory stage and the word-wide data RAM (mem_data).
- The RAM only does whole 32-bit reads (1-cycle registered latency) and whole 32-bit writes.
- This block adds byte and halfword loads with sign/zero extension.
- Sub-word stores are done as read-modify-write.
- Misaligned and illegal-size accesses are rejected with an error response and no RAM access.

Parameters:
RESET_RDATA, 32'h0, reset value of rsp_rdata_o and mem_data_w_o.

Ports:
clk_i  in  1  clock.
rst_i  in  1  reset; asynchronous, active-high.
req_valid_i  in  1  core request valid.
req_ready_o  out  1  block idle, can accept.
req_we_i  in  1  1 = store, 0 = load.
req_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal.
req_unsigned_i  in  1  load zero-extends when 1.
req_addr_i  in  32  byte address.
req_wdata_i  in  32  store data, right-aligned.
rsp_valid_o  out  1  one-cycle completion pulse.
rsp_err_o  out  1  valid with rsp_valid_o; misaligned or illegal size.
rsp_rdata_o  out  32  load result, held until next load response.
mem_r_en_o  out  1  RAM read enable.
mem_addr_r_o  out  32  RAM read byte address, [1:0]=0.
mem_data_r_i  in  32  RAM read data, valid the cycle after mem_r_en_o.
mem_wr_en_o  out  1  RAM write enable.
mem_addr_w_o  out  32  RAM write byte address, [1:0]=0.
mem_data_w_o  out  32  RAM write data.

Behaviour:
- Reset values: state IDLE; all registers and outputs 0, except rsp_rdata_o and mem_data_w_o = RESET_RDATA.
  - req_ready_o is 0 while rst_i is high, 1 after release.
- FSM states: IDLE, READ, MERGE, WRITE, RESP.
- Outputs decoded from registered state only:
  - req_ready_o = IDLE.
  - mem_r_en_o = READ.
  - mem_wr_en_o = WRITE.
  - rsp_valid_o = RESP or WRITE.
- Accept: req_valid_i & req_ready_o at a rising edge. All request fields are latched; inputs are ignored until back in IDLE.
- Word address latched = {req_addr_i[31:2], 2'b00}. It drives both mem_addr_r_o and mem_addr_w_o.
- Error check at accept:
  - size 11 is an error.
  - half with addr[0]=1 is an error.
  - word with addr[1:0]!=0 is an error.
  - Error path: go to RESP with err=1. No RAM enable is ever raised; rsp_rdata_o is unchanged.
- Load, IDLE->READ->MERGE->RESP->IDLE:
  - In MERGE, select from mem_data_r_i: byte lane addr[1:0], half lane addr[1], or the whole word.
  - Sign-extend (or zero-extend when unsigned) into rsp_rdata_o.
  - Response pulse arrives 3 cycles after the accept edge.
- Word store, IDLE->WRITE->IDLE:
  - mem_data_w_o = wdata.
  - rsp_valid_o is asserted in the same cycle as mem_wr_en_o.
  - Latency 1 cycle.
- Sub-word store, IDLE->READ->MERGE->WRITE->IDLE:
  - In MERGE, replace the addressed lane of mem_data_r_i with wdata[7:0] or wdata[15:0]. Other lanes are preserved bit-exact.
  - WRITE pulse arrives 3 cycles after the accept edge.
- Sign/unsigned flag is ignored for stores.
- At most one outstanding request. rsp has no backpressure.
- A new request may be accepted in the first IDLE cycle after RESP/WRITE, giving back-to-back throughput of 2 cycles for a word store.
- rsp_err_o is 0 whenever rsp_valid_o is 0.
- Reset asserted mid-operation (any state): immediate return to IDLE.
  - A pending RMW never writes; the op is dropped silently with no response.
  - mem_wr_en_o drops asynchronously.
- mem_data_r_i is sampled only in MERGE. Its value in other cycles is don't-care.

Test Plan:
- RAM word 0x40 = 0x8899AABB.
  - lb addr 0x43 gives rdata 0xFFFFFF88.
  - lbu 0x43 gives 0x00000088.
  - lh 0x40 gives 0xFFFFAABB.
  - lhu 0x42 gives 0x00008899.
  - Each pulses rsp_valid_o exactly 3 cycles after accept, with err=0.
- sb 0x41 data 0x123456CC onto 0x8899AABB: one read of 0x40, then one write of 0x8899CCBB 3 cycles after accept; subsequent lw 0x40 returns 0x8899CCBB.
- sh 0x42 data 0x0000BEEF onto 0x11223344 writes 0xBEEF3344. Then sw 0x44 of 0xDEADBEEF: write on the next cycle, no read issued.
- Misaligned lw 0x46, sh 0x41, and size 11:
  - each gives rsp_valid_o=1, rsp_err_o=1 one cycle after accept;
  - mem_r_en_o and mem_wr_en_o stay 0;
  - rsp_rdata_o is unchanged.
- Assert rst_i during MERGE of sb 0x40: no mem_wr_en_o pulse, no rsp_valid_o. After release, req_ready_o=1 and the RAM word is unchanged.
- req_valid_i held high with changing fields while busy: only the first request is accepted; latched address/data are unaffected by input changes until IDLE.
